input_vc_ctrl: RTL and testbench
================================

INPUT_VC_CTRL -- requirements
Module: input_vc_ctrl

Interface
REQ-001 SHALL have parameter X_CURRENT, default 0, router x coordinate used for XY route computation.
REQ-002 SHALL have parameter Y_CURRENT, default 0, router y coordinate used for XY route computation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flit_i  input  flit_novc_t  flit at head of the VC's circular buffer.
REQ-006 SHALL have port is_empty_i  input  1  buffer empty flag.
REQ-007 SHALL have port read_o  output  1  pop strobe to the buffer; combinational.
REQ-008 SHALL have port va_request_o  output  1  VC-allocation request.
REQ-009 SHALL have port out_port_o  output  port_t  latched route-computation result.
REQ-010 SHALL have port vc_valid_i  input  1  VC-allocation grant.
REQ-011 SHALL have port vc_new_i  input  [VC_SIZE-1:0]  downstream VC granted.
REQ-012 SHALL have port sa_request_o  output  1  switch-allocation request.
REQ-013 SHALL have port sa_grant_i  input  1  switch-allocation grant.
REQ-014 SHALL have port flit_o  output  flit_t  flit to the crossbar, carrying the granted VC id.
REQ-015 SHALL have port flit_valid_o  output  1  flit_o qualifier.
REQ-016 SHALL have port error_o  output  1  one-cycle pulse on a flit-type protocol violation.

Function
REQ-017 SHALL implement FSM states IDLE, VA, ACTIVE.
REQ-018 In IDLE with ~is_empty_i and flit_i type HEAD or HEADTAIL, SHALL latch out_port_o from XY routing and enter VA next cycle.
REQ-019 XY routing SHALL select EAST if dest_x>X_CURRENT, else WEST if dest_x<X_CURRENT, else SOUTH if dest_y>Y_CURRENT, else NORTH if dest_y<Y_CURRENT, else LOCAL; comparisons unsigned.
REQ-020 In VA, va_request_o SHALL be 1; on vc_valid_i SHALL latch vc_new_i and enter ACTIVE next cycle.
REQ-021 In ACTIVE, sa_request_o SHALL equal ~is_empty_i; it SHALL be 0 in all other states.
REQ-022 read_o SHALL equal (state==ACTIVE) & sa_grant_i & ~is_empty_i; sa_grant_i with is_empty_i set SHALL be ignored.
REQ-023 One cycle after read_o, flit_o SHALL hold the popped flit with vc_id = latched VC, and flit_valid_o SHALL be 1 for exactly that cycle.
REQ-024 Popping a TAIL or HEADTAIL flit in ACTIVE SHALL return the FSM to IDLE next cycle; a new head SHALL NOT be accepted in that same cycle.
REQ-025 In IDLE with ~is_empty_i and a BODY or TAIL flit, SHALL assert read_o (drop), pulse error_o next cycle, and remain in IDLE.
REQ-026 Popping a HEAD flit in ACTIVE SHALL pulse error_o next cycle, forward the flit normally, and stay in ACTIVE.
REQ-027 In VA, flits SHALL NOT be popped regardless of sa_grant_i.

Reset
REQ-028 On rst at a clock edge: state=IDLE, out_port_o=LOCAL, latched VC=0, flit_valid_o=0, error_o=0, va_request_o=0, sa_request_o=0.
REQ-029 rst asserted mid-packet SHALL abandon the packet; no flit_valid_o SHALL follow the reset edge.
REQ-030 flit_o data SHALL be don't-care while flit_valid_o=0.

Structure
REQ-031 flit_t, flit_novc_t, flit_label_t, port_t, VC_SIZE, and coordinate widths SHALL live in noc_params.
REQ-032 The FSM state enum SHALL be local to the module.
REQ-033 XY route computation SHALL be a sub-module, rc_unit, which is purely combinational.

Verification
REQ-034 HEADTAIL at (X+1,Y), vc_valid_i=1 with vc_new_i=2, sa_grant_i=1 -> out_port_o=EAST, one flit_o with vc_id=2, back to IDLE.
REQ-035 HEAD+2 BODY+TAIL to LOCAL, sa_grant_i held high -> four consecutive flit_valid_o pulses in order, then IDLE.
REQ-036 BODY flit while IDLE -> read_o=1 that cycle, error_o=1 next cycle, flit_valid_o=0.
REQ-037 ACTIVE, buffer empty, sa_grant_i=1 -> read_o=0 and sa_request_o=0; the flit arriving later is forwarded on its next grant.
REQ-038 rst asserted in ACTIVE after one body flit -> next cycle state IDLE, all outputs at reset values, no flit_valid_o.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC types and sizes: flit formats, output-port encoding, VC and
// mesh coordinate widths.
package noc_params;

   localparam int MESH_SIZE_X       = 4;
   localparam int MESH_SIZE_Y       = 4;
   localparam int DEST_ADDR_SIZE_X  = $clog2(MESH_SIZE_X);
   localparam int DEST_ADDR_SIZE_Y  = $clog2(MESH_SIZE_Y);
   localparam int VC_NUM            = 4;
   localparam int VC_SIZE           = $clog2(VC_NUM);
   localparam int FLIT_DATA_SIZE    = 16;
   localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

   typedef enum logic [1:0] {
      HEAD,
      BODY,
      TAIL,
      HEADTAIL
   } flit_label_t;

   typedef enum logic [2:0] {
      LOCAL,
      NORTH,
      SOUTH,
      WEST,
      EAST
   } port_t;

   // Layout of the data field of a head (or headtail) flit.
   typedef struct packed {
      logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
      logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
      logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   } head_data_t;

   // Flit as stored in an input buffer, before a downstream VC is known.
   typedef struct packed {
      flit_label_t               flit_label;
      logic [FLIT_DATA_SIZE-1:0] data;
   } flit_novc_t;

   // Flit as sent to the crossbar, tagged with the downstream VC.
   typedef struct packed {
      flit_label_t               flit_label;
      logic [VC_SIZE-1:0]        vc_id;
      logic [FLIT_DATA_SIZE-1:0] data;
   } flit_t;

   function automatic head_data_t head_fields(input logic [FLIT_DATA_SIZE-1:0] data);
      return head_data_t'(data);
   endfunction

endpackage

// File: rtl/rc_unit.sv
// XY dimension-order route computation; purely combinational.
module rc_unit
   import noc_params::*;
#(
   parameter int unsigned X_CURRENT = 0,
   parameter int unsigned Y_CURRENT = 0
) (
   input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
   input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
   output port_t                       out_port_o
);

   localparam logic [DEST_ADDR_SIZE_X-1:0] X_CUR = DEST_ADDR_SIZE_X'(X_CURRENT);
   localparam logic [DEST_ADDR_SIZE_Y-1:0] Y_CUR = DEST_ADDR_SIZE_Y'(Y_CURRENT);

   // Resolve X first, then Y; only a fully matching destination ejects locally.
   always_comb begin
      out_port_o = LOCAL;
      if (x_dest_i > X_CUR)       out_port_o = EAST;
      else if (x_dest_i < X_CUR)  out_port_o = WEST;
      else if (y_dest_i > Y_CUR)  out_port_o = SOUTH;
      else if (y_dest_i < Y_CUR)  out_port_o = NORTH;
   end

endmodule

// File: rtl/input_vc_ctrl.sv
// Per-VC input controller: routes the head flit, requests a downstream VC,
// then pops and forwards the packet's flits on switch-allocation grants.
module input_vc_ctrl
   import noc_params::*;
#(
   parameter int unsigned X_CURRENT = 0,
   parameter int unsigned Y_CURRENT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  flit_novc_t         flit_i,
   input  logic               is_empty_i,
   output logic               read_o,
   output logic               va_request_o,
   output port_t              out_port_o,
   input  logic               vc_valid_i,
   input  logic [VC_SIZE-1:0] vc_new_i,
   output logic               sa_request_o,
   input  logic               sa_grant_i,
   output flit_t              flit_o,
   output logic               flit_valid_o,
   output logic               error_o
);

   typedef enum logic [1:0] {
      IDLE,
      VA,
      ACTIVE
   } state_t;

   state_t             state_q,        state_d;
   port_t              out_port_q,     out_port_d;
   logic [VC_SIZE-1:0] vc_q,           vc_d;
   flit_t              flit_q,         flit_d;
   logic               flit_valid_q,   flit_valid_d;
   logic               error_q,        error_d;
   // Set while the packet's own head flit is still waiting to be forwarded,
   // so only a second HEAD inside a packet counts as a violation.
   logic               head_pending_q, head_pending_d;

   port_t              rc_port;
   head_data_t         head_info;

   assign head_info = head_fields(flit_i.data);

   rc_unit #(
      .X_CURRENT (X_CURRENT),
      .Y_CURRENT (Y_CURRENT)
   ) u_rc_unit (
      .x_dest_i   (head_info.x_dest),
      .y_dest_i   (head_info.y_dest),
      .out_port_o (rc_port)
   );

   // Next-state, latched-field updates and combinational strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d        = state_q;
      out_port_d     = out_port_q;
      vc_d           = vc_q;
      flit_d         = flit_q;
      head_pending_d = head_pending_q;
      flit_valid_d   = 1'b0;
      error_d        = 1'b0;
      read_o         = 1'b0;
      va_request_o   = 1'b0;
      sa_request_o   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!is_empty_i) begin
               if (flit_i.flit_label == HEAD || flit_i.flit_label == HEADTAIL) begin
                  // Head stays in the buffer; it is popped once a VC is held.
                  out_port_d = rc_port;
                  state_d    = VA;
               end else begin
                  // Orphan body/tail flit: drop it and flag the violation.
                  read_o  = 1'b1;
                  error_d = 1'b1;
               end
            end
         end

         VA: begin
            va_request_o = 1'b1;
            if (vc_valid_i) begin
               vc_d           = vc_new_i;
               head_pending_d = 1'b1;
               state_d        = ACTIVE;
            end
         end

         ACTIVE: begin
            sa_request_o = !is_empty_i;
            if (sa_grant_i && !is_empty_i) begin
               read_o         = 1'b1;
               flit_d         = '{flit_label: flit_i.flit_label, vc_id: vc_q, data: flit_i.data};
               flit_valid_d   = 1'b1;
               head_pending_d = 1'b0;
               if (flit_i.flit_label == HEAD && !head_pending_q) error_d = 1'b1;
               if (flit_i.flit_label == TAIL || flit_i.flit_label == HEADTAIL) state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state_q        <= IDLE;
         out_port_q     <= LOCAL;
         vc_q           <= '0;
         flit_valid_q   <= 1'b0;
         error_q        <= 1'b0;
         head_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         out_port_q     <= out_port_d;
         vc_q           <= vc_d;
         flit_valid_q   <= flit_valid_d;
         error_q        <= error_d;
         head_pending_q <= head_pending_d;
      end
   end

   // Outgoing flit register; contents only matter while flit_valid_o is high.
   always_ff @(posedge clk) begin
      // NOTE: this datapath register is deliberately left out of reset; its
      // qualifier is reset, which is enough and keeps the data flops plain.
      flit_q <= flit_d;
   end

   assign out_port_o   = out_port_q;
   assign flit_o       = flit_q;
   assign flit_valid_o = flit_valid_q;
   assign error_o      = error_q;

endmodule

// File: tb/tb_input_vc_ctrl.sv
// Directed testbench for input_vc_ctrl with a small behavioural input buffer.
module tb_input_vc_ctrl;
   import noc_params::*;

   localparam int unsigned X_CUR = 1;
   localparam int unsigned Y_CUR = 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   flit_novc_t         flit_i;
   logic               is_empty_i;
   logic               read_o;
   logic               va_request_o;
   port_t              out_port_o;
   logic               vc_valid_i = 1'b0;
   logic [VC_SIZE-1:0] vc_new_i = '0;
   logic               sa_request_o;
   logic               sa_grant_i = 1'b0;
   flit_t              flit_o;
   logic               flit_valid_o;
   logic               error_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural circular buffer: written by the stimulus, popped on read_o.
   flit_novc_t mem [64];
   logic [5:0] wr = '0;
   logic [5:0] rd = '0;
   logic       flush = 1'b0;

   assign is_empty_i = (rd == wr);
   assign flit_i     = mem[rd];

   always @(posedge clk) begin
      if (flush) rd <= wr;
      else if (read_o && rd != wr) rd <= rd + 6'd1;
   end

   always #5 clk = ~clk;

   input_vc_ctrl #(.X_CURRENT(X_CUR), .Y_CURRENT(Y_CUR)) dut (
      .clk          (clk),
      .rst          (rst),
      .flit_i       (flit_i),
      .is_empty_i   (is_empty_i),
      .read_o       (read_o),
      .va_request_o (va_request_o),
      .out_port_o   (out_port_o),
      .vc_valid_i   (vc_valid_i),
      .vc_new_i     (vc_new_i),
      .sa_request_o (sa_request_o),
      .sa_grant_i   (sa_grant_i),
      .flit_o       (flit_o),
      .flit_valid_o (flit_valid_o),
      .error_o      (error_o)
   );

   function automatic logic [FLIT_DATA_SIZE-1:0] hdata(input int x, input int y, input int pl);
      return {2'(x), 2'(y), 12'(pl)};
   endfunction

   task automatic push(input flit_label_t lbl, input logic [FLIT_DATA_SIZE-1:0] d);
      mem[wr] = '{flit_label: lbl, data: d};
      wr      = wr + 6'd1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b1; vc_valid_i = 1'b0; sa_grant_i = 1'b0; vc_new_i = '0;
      tick();
      rst = 1'b0; flush = 1'b0;
      settle();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (out_port_o !== LOCAL) begin n_fail++; $display("FAIL rst_out_port got %0d want %0d", out_port_o, LOCAL); end
      n_tests++; if ({va_request_o, sa_request_o, read_o} !== 3'b000) begin n_fail++; $display("FAIL rst_requests got %b want 000", {va_request_o, sa_request_o, read_o}); end
      n_tests++; if ({flit_valid_o, error_o} !== 2'b00) begin n_fail++; $display("FAIL rst_valid_err got %b want 00", {flit_valid_o, error_o}); end
   endtask

   task automatic test_routes();
      int    xs [5] = '{0, 1, 1, 1, 3};
      int    ys [5] = '{1, 2, 0, 1, 0};
      port_t exp [5] = '{WEST, SOUTH, NORTH, LOCAL, EAST};
      for (int i = 0; i < 5; i++) begin
         do_reset();
         push(HEAD, hdata(xs[i], ys[i], 12'h100 + i));
         settle();
         tick();
         n_tests++; if (out_port_o !== exp[i] || va_request_o !== 1'b1) begin
            n_fail++; $display("FAIL route_%0d got port %0d va %b want port %0d va 1", i, out_port_o, va_request_o, exp[i]);
         end
      end
   endtask

   task automatic test_headtail_east();
      flit_t e;
      do_reset();
      vc_valid_i = 1'b1; vc_new_i = 2'd2; sa_grant_i = 1'b1;
      push(HEADTAIL, hdata(2, 1, 12'h5A5));
      settle();
      n_tests++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL ht_idle_read got %b want 0", read_o); end
      tick();
      n_tests++; if (out_port_o !== EAST || va_request_o !== 1'b1 || read_o !== 1'b0) begin
         n_fail++; $display("FAIL ht_va got port %0d va %b read %b want port %0d va 1 read 0", out_port_o, va_request_o, read_o, EAST);
      end
      tick();
      n_tests++; if ({sa_request_o, read_o, flit_valid_o} !== 3'b110) begin n_fail++; $display("FAIL ht_active got %b want 110", {sa_request_o, read_o, flit_valid_o}); end
      tick();
      e = '{flit_label: HEADTAIL, vc_id: 2'd2, data: hdata(2, 1, 12'h5A5)};
      n_tests++; if (flit_valid_o !== 1'b1 || flit_o !== e) begin n_fail++; $display("FAIL ht_flit got v%b %h want v1 %h", flit_valid_o, flit_o, e); end
      n_tests++; if ({va_request_o, sa_request_o, error_o} !== 3'b000) begin n_fail++; $display("FAIL ht_back_idle got %b want 000", {va_request_o, sa_request_o, error_o}); end
      tick();
      n_tests++; if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL ht_single_pulse got %b want 0", flit_valid_o); end
   endtask

   task automatic test_back_to_back();
      flit_label_t lbl [4] = '{HEAD, BODY, BODY, TAIL};
      logic [FLIT_DATA_SIZE-1:0] dat [4];
      flit_t e;
      do_reset();
      dat[0] = hdata(1, 1, 12'h011); dat[1] = 16'hB001; dat[2] = 16'hB002; dat[3] = 16'h7EEE;
      vc_valid_i = 1'b1; vc_new_i = 2'd1; sa_grant_i = 1'b1;
      for (int i = 0; i < 4; i++) push(lbl[i], dat[i]);
      tick();
      n_tests++; if (out_port_o !== LOCAL) begin n_fail++; $display("FAIL b2b_port got %0d want %0d", out_port_o, LOCAL); end
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         e = '{flit_label: lbl[i], vc_id: 2'd1, data: dat[i]};
         n_tests++; if (flit_valid_o !== 1'b1 || flit_o !== e || error_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_flit_%0d got v%b e%b %h want v1 e0 %h", i, flit_valid_o, error_o, flit_o, e);
         end
      end
      n_tests++; if ({va_request_o, sa_request_o, read_o} !== 3'b000) begin n_fail++; $display("FAIL b2b_idle got %b want 000", {va_request_o, sa_request_o, read_o}); end
      tick();
      n_tests++; if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", flit_valid_o); end
   endtask

   task automatic test_idle_body();
      do_reset();
      push(BODY, 16'hBAD0);
      settle();
      n_tests++; if (read_o !== 1'b1 || va_request_o !== 1'b0) begin n_fail++; $display("FAIL ib_drop got read %b va %b want 1 0", read_o, va_request_o); end
      tick();
      n_tests++; if ({error_o, flit_valid_o, va_request_o} !== 3'b100) begin n_fail++; $display("FAIL ib_err got %b want 100", {error_o, flit_valid_o, va_request_o}); end
      tick();
      n_tests++; if (error_o !== 1'b0) begin n_fail++; $display("FAIL ib_err_pulse got %b want 0", error_o); end
   endtask

   task automatic test_empty_grant();
      flit_t e;
      do_reset();
      vc_valid_i = 1'b1; vc_new_i = 2'd3; sa_grant_i = 1'b1;
      push(HEAD, hdata(1, 1, 12'h222));
      tick(); tick(); tick();
      n_tests++; if (flit_valid_o !== 1'b1) begin n_fail++; $display("FAIL eg_head got %b want 1", flit_valid_o); end
      n_tests++; if ({read_o, sa_request_o} !== 2'b00) begin n_fail++; $display("FAIL eg_empty got %b want 00", {read_o, sa_request_o}); end
      tick();
      n_tests++; if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL eg_no_flit got %b want 0", flit_valid_o); end
      sa_grant_i = 1'b0;
      push(TAIL, 16'hCAFE);
      settle();
      n_tests++; if ({sa_request_o, read_o} !== 2'b10) begin n_fail++; $display("FAIL eg_req got %b want 10", {sa_request_o, read_o}); end
      tick();
      n_tests++; if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL eg_wait got %b want 0", flit_valid_o); end
      sa_grant_i = 1'b1;
      settle();
      n_tests++; if (read_o !== 1'b1) begin n_fail++; $display("FAIL eg_read got %b want 1", read_o); end
      tick();
      e = '{flit_label: TAIL, vc_id: 2'd3, data: 16'hCAFE};
      n_tests++; if (flit_valid_o !== 1'b1 || flit_o !== e) begin n_fail++; $display("FAIL eg_tail got v%b %h want v1 %h", flit_valid_o, flit_o, e); end
   endtask

   task automatic test_head_in_active();
      flit_t e;
      do_reset();
      vc_valid_i = 1'b1; vc_new_i = 2'd0; sa_grant_i = 1'b1;
      push(HEAD, hdata(1, 1, 12'h333));
      push(HEAD, hdata(1, 1, 12'h444));
      push(TAIL, 16'h5555);
      tick(); tick(); tick();
      n_tests++; if (flit_valid_o !== 1'b1 || error_o !== 1'b0) begin n_fail++; $display("FAIL ha_first got v%b e%b want v1 e0", flit_valid_o, error_o); end
      tick();
      e = '{flit_label: HEAD, vc_id: 2'd0, data: hdata(1, 1, 12'h444)};
      n_tests++; if (flit_valid_o !== 1'b1 || error_o !== 1'b1 || flit_o !== e) begin
         n_fail++; $display("FAIL ha_second got v%b e%b %h want v1 e1 %h", flit_valid_o, error_o, flit_o, e);
      end
      n_tests++; if (sa_request_o !== 1'b1) begin n_fail++; $display("FAIL ha_still_active got %b want 1", sa_request_o); end
      tick();
      n_tests++; if (flit_valid_o !== 1'b1 || error_o !== 1'b0 || flit_o.flit_label !== TAIL) begin
         n_fail++; $display("FAIL ha_tail got v%b e%b lbl %0d want v1 e0 lbl %0d", flit_valid_o, error_o, flit_o.flit_label, TAIL);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      vc_valid_i = 1'b1; vc_new_i = 2'd2; sa_grant_i = 1'b1;
      push(HEAD, hdata(3, 3, 12'h666));
      push(BODY, 16'h0001);
      push(BODY, 16'h0002);
      push(TAIL, 16'h0003);
      tick(); tick(); tick();
      n_tests++; if (out_port_o !== EAST || flit_valid_o !== 1'b1) begin n_fail++; $display("FAIL rm_pre got port %0d v%b want %0d v1", out_port_o, flit_valid_o, EAST); end
      rst = 1'b1; flush = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0; vc_valid_i = 1'b0;
      settle();
      n_tests++; if (out_port_o !== LOCAL || {va_request_o, sa_request_o, read_o} !== 3'b000) begin
         n_fail++; $display("FAIL rm_outputs got port %0d req %b want %0d 000", out_port_o, {va_request_o, sa_request_o, read_o}, LOCAL);
      end
      n_tests++; if ({flit_valid_o, error_o} !== 2'b00) begin n_fail++; $display("FAIL rm_valid got %b want 00", {flit_valid_o, error_o}); end
      tick();
      n_tests++; if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_after got %b want 0", flit_valid_o); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '{flit_label: BODY, data: '0};
      test_reset();
      test_routes();
      test_headtail_east();
      test_back_to_back();
      test_idle_body();
      test_empty_grant();
      test_head_in_active();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
